change_dispenser: RTL

CHANGE_DISPENSER -- requirements
Module: change_dispenser

---
 rtl/vend_pkg.sv | 31 +++
 rtl/coin_select.sv | 20 ++
 rtl/change_dispenser.sv | 117 +++++++++++
 3 files changed

// File: rtl/vend_pkg.sv
// Shared vending definitions: coin denominations, one-hot coin bit positions and FSM states.
// Used by both the coin acceptor and the change dispenser.
package vend_pkg;

  localparam logic [7:0] VAL_50 = 8'd50;
  localparam logic [7:0] VAL_20 = 8'd20;
  localparam logic [7:0] VAL_10 = 8'd10;
  localparam logic [7:0] VAL_5  = 8'd5;

  localparam int BIT_50 = 3;
  localparam int BIT_20 = 2;
  localparam int BIT_10 = 1;
  localparam int BIT_5  = 0;

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    PULSE,
    GAP,
    FIN
  } state_t;

  function automatic logic [7:0] coin_value(input logic [3:0] coin);
    coin_value = 8'd0;
    if (coin[BIT_50])      coin_value = VAL_50;
    else if (coin[BIT_20]) coin_value = VAL_20;
    else if (coin[BIT_10]) coin_value = VAL_10;
    else if (coin[BIT_5])  coin_value = VAL_5;
  endfunction

endpackage

// File: rtl/coin_select.sv
// Greedy chooser: picks the largest available denomination that still fits in remaining.
module coin_select
  import vend_pkg::*;
(
  input  logic [7:0] remaining,
  input  logic [3:0] avail,
  output logic [3:0] coin,
  output logic       valid
);

  always_comb begin
    coin = 4'b0000;
    if (avail[BIT_50] && remaining >= VAL_50)      coin[BIT_50] = 1'b1;
    else if (avail[BIT_20] && remaining >= VAL_20) coin[BIT_20] = 1'b1;
    else if (avail[BIT_10] && remaining >= VAL_10) coin[BIT_10] = 1'b1;
    else if (avail[BIT_5] && remaining >= VAL_5)   coin[BIT_5]  = 1'b1;
    valid = |coin;
  end

endmodule

// File: rtl/change_dispenser.sv
// Change dispenser: pays out an amount as one-hot coin pulses, largest denomination first.
// Optional macro COIN_STOCK_EN adds per-denomination stock counters with refill/short ports.
module change_dispenser
  import vend_pkg::*;
#(
  parameter int STOCK_INIT = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] amount,
  output logic [3:0] coin_out,
  output logic       busy,
  output logic       done,
  output logic [7:0] remainder
`ifdef COIN_STOCK_EN
  ,
  input  logic       refill,
  output logic       short
`endif
);

  state_t     state;
  logic [7:0] remaining;
  logic [3:0] sel_coin;
  logic [3:0] pick;
  logic       pick_valid;
  logic [3:0] avail;

  coin_select u_coin_select (
    .remaining(remaining),
    .avail    (avail),
    .coin     (pick),
    .valid    (pick_valid)
  );

`ifdef COIN_STOCK_EN
  logic [7:0] stock [4];

  // Counters only change while idle (refill) or on the cycle a coin actually leaves.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) stock[i] <= 8'(STOCK_INIT);
    end else if (state == IDLE && refill) begin
      for (int i = 0; i < 4; i++) stock[i] <= 8'(STOCK_INIT);
    end else if (state == PULSE) begin
      for (int i = 0; i < 4; i++)
        if (sel_coin[i]) stock[i] <= stock[i] - 8'd1;
    end
  end

  always_comb begin
    avail = 4'b0000;
    for (int i = 0; i < 4; i++) avail[i] = (stock[i] != 8'd0);
  end
`else
  assign avail = 4'b1111;
`endif

  // Coin is chosen in SELECT and emitted in PULSE so every coin costs SELECT/PULSE/GAP.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      remaining <= 8'd0;
      sel_coin  <= 4'b0000;
      coin_out  <= 4'b0000;
      busy      <= 1'b0;
      done      <= 1'b0;
      remainder <= 8'd0;
`ifdef COIN_STOCK_EN
      short     <= 1'b0;
`endif
    end else begin
      done     <= 1'b0;
      coin_out <= 4'b0000;
      case (state)
        IDLE: begin
          if (start) begin
            remaining <= amount;
            busy      <= 1'b1;
            state     <= SELECT;
`ifdef COIN_STOCK_EN
            short     <= 1'b0;
`endif
          end
        end
        SELECT: begin
          if (pick_valid) begin
            sel_coin <= pick;
            state    <= PULSE;
          end else begin
            state <= FIN;
          end
        end
        PULSE: begin
          coin_out  <= sel_coin;
          remaining <= remaining - coin_value(sel_coin);
          state     <= GAP;
        end
        GAP: begin
          state <= SELECT;
        end
        FIN: begin
          done      <= 1'b1;
          busy      <= 1'b0;
          remainder <= remaining;
`ifdef COIN_STOCK_EN
          short     <= (remaining >= VAL_5);
`endif
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
